// File: rtl/bpm_pkg.sv
// Shared definitions for the branch-prediction performance monitor.
package bpm_pkg;

    typedef enum logic [1:0] {
        BPM_IDLE  = 2'd0,
        BPM_RUN   = 2'd1,
        BPM_DRAIN = 2'd2,
        BPM_DONE  = 2'd3
    } bpm_state_e;

    // Read-port address map
    localparam logic [2:0] BPM_ADDR_CYC  = 3'd0;
    localparam logic [2:0] BPM_ADDR_INST = 3'd1;
    localparam logic [2:0] BPM_ADDR_BR   = 3'd2;
    localparam logic [2:0] BPM_ADDR_MISS = 3'd3;
    localparam logic [2:0] BPM_ADDR_STAT = 3'd4;

    // Counter slots, also the overflow-flag bit order in the status word
    localparam int unsigned BPM_IDX_CYC  = 0;
    localparam int unsigned BPM_IDX_INST = 1;
    localparam int unsigned BPM_IDX_BR   = 2;
    localparam int unsigned BPM_IDX_MISS = 3;

    // Instruction encodings observed on the IF-stage probe
    localparam logic [31:0] BPM_NOP_INSN  = 32'h0000_0013;
    localparam logic [31:0] BPM_HALT_INSN = 32'h0000_006F;

    localparam int unsigned BPM_STAT_W = 8;

    // Status word: [1:0] state, [7:4] overflow flags {miss, br, inst, cyc}
    function automatic logic [BPM_STAT_W-1:0] bpm_status(input bpm_state_e st,
                                                         input logic [3:0] ovf);
        return {ovf, 2'b00, st};
    endfunction

endpackage

// File: rtl/bpm_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
module bpm_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next value: clear beats increment; an increment at all-ones is dropped and flagged
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/br_perf_monitor.sv
// Branch-prediction performance monitor: windows cycle/instruction/branch/miss
// counts, auto-stops on a halt loop, drains in-flight branches, then freezes.
module br_perf_monitor
    import bpm_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned DRAIN_CYC     = 3,
    parameter logic [31:0] HALT_INSN     = BPM_HALT_INSN,
    parameter int unsigned HALT_RPT      = 4,
    parameter logic [31:0] NOP_INSN      = BPM_NOP_INSN,
    parameter bit          MISS_NEEDS_BR = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             br_instr_i,
    input  logic             br_miss_i,
    input  logic [31:0]      instr_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic             rd_req_i,
    input  logic [2:0]       rd_addr_i,
    output logic             rd_vld_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam int unsigned HLT_W = (HALT_RPT > 1) ? $clog2(HALT_RPT + 1) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC);
    localparam logic [HLT_W-1:0] HLT_MAX  = HLT_W'(HALT_RPT);
    localparam int unsigned STW = (CNT_W < BPM_STAT_W) ? CNT_W : BPM_STAT_W;

    bpm_state_e       state_q;
    logic [DRN_W-1:0] drn_q;
    logic [HLT_W-1:0] hlt_q, hlt_d;
    logic             halt_hit;
    logic             busy_q, done_q;

    logic             in_run, in_cap, valid_insn;
    logic [3:0]       cnt_en;
    logic [3:0]       cnt_ovf;
    logic [CNT_W-1:0] cnt [4];

    logic [BPM_STAT_W-1:0] stat_w;
    logic [CNT_W-1:0]      rd_stat, rd_mux;
    logic [CNT_W-1:0]      rd_data_q;
    logic                  rd_vld_q;

    // Halt run-length next value, saturating at HALT_RPT
    always_comb begin
        hlt_d = '0;
        if (instr_i == HALT_INSN) begin
            hlt_d = (hlt_q >= HLT_MAX) ? HLT_MAX : hlt_q + 1'b1;
        end
    end

    assign halt_hit = (hlt_d >= HLT_MAX);

    // Window FSM with registered busy/done; clear > stop > start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BPM_IDLE;
            drn_q   <= '0;
            hlt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= BPM_IDLE;
            drn_q   <= '0;
            hlt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                BPM_IDLE: begin
                    if (start_i && !stop_i) begin
                        state_q <= BPM_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                BPM_RUN: begin
                    hlt_q <= hlt_d;
                    if (stop_i || halt_hit) begin
                        if (DRAIN_CYC == 0) begin
                            state_q <= BPM_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= BPM_DRAIN;
                            drn_q   <= DRN_LOAD;
                        end
                    end
                end
                BPM_DRAIN: begin
                    if (drn_q <= DRN_W'(1)) begin
                        drn_q   <= '0;
                        state_q <= BPM_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drn_q <= drn_q - 1'b1;
                    end
                end
                BPM_DONE: begin
                    if (start_i && !stop_i) begin
                        state_q <= BPM_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= BPM_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Count enables: cycles/instructions only in RUN, branches/misses also while draining
    always_comb begin
        in_run     = (state_q == BPM_RUN);
        in_cap     = in_run || (state_q == BPM_DRAIN);
        valid_insn = (instr_i != NOP_INSN) && (instr_i != '0) && (instr_i != HALT_INSN);
        cnt_en               = '0;
        cnt_en[BPM_IDX_CYC]  = in_run;
        cnt_en[BPM_IDX_INST] = in_run && valid_insn;
        cnt_en[BPM_IDX_BR]   = in_cap && br_instr_i;
        cnt_en[BPM_IDX_MISS] = in_cap && br_miss_i && (!MISS_NEEDS_BR || br_instr_i);
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        bpm_sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clear_i),
            .en_i   (cnt_en[g]),
            .cnt_o  (cnt[g]),
            .ovf_o  (cnt_ovf[g])
        );
    end

    // Read mux; status word is truncated when counters are narrower than 8 bits
    always_comb begin
        stat_w  = bpm_status(state_q, cnt_ovf);
        rd_stat = '0;
        rd_stat[STW-1:0] = stat_w[STW-1:0];
        unique case (rd_addr_i)
            BPM_ADDR_CYC:  rd_mux = cnt[BPM_IDX_CYC];
            BPM_ADDR_INST: rd_mux = cnt[BPM_IDX_INST];
            BPM_ADDR_BR:   rd_mux = cnt[BPM_IDX_BR];
            BPM_ADDR_MISS: rd_mux = cnt[BPM_IDX_MISS];
            BPM_ADDR_STAT: rd_mux = rd_stat;
            default:       rd_mux = '0;
        endcase
    end

    // One-cycle read response; data holds between reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign rd_vld_o  = rd_vld_q;
    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
